// File: rtl/dmem_burst_master.sv
// Burst master: turns write/read burst commands into single-port RAM cycles, with a 2-entry read buffer.
// Optional byte-write mask port and latching enabled by macro DMEM_BURST_BE_EN.
module dmem_burst_master #(
    parameter int ADDR_MSB = 9
) (
    input  logic                mclk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_MSB:0]   cmd_addr,
    input  logic [7:0]          cmd_len,
`ifdef DMEM_BURST_BE_EN
    input  logic [1:0]          cmd_be,
`endif
    input  logic                wdata_valid,
    output logic                wdata_ready,
    input  logic [15:0]         wdata,
    output logic                rdata_valid,
    input  logic                rdata_ready,
    output logic [15:0]         rdata,
    output logic                busy,
    output logic                done,
    output logic                ena,
    output logic [1:0]          wea,
    output logic [ADDR_MSB:0]   addra,
    output logic [15:0]         dina,
    input  logic [15:0]         douta
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_FLUSH} state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_live;
    logic                r_wr;
    logic [ADDR_MSB:0]   r_addr;
    logic [7:0]          r_cnt;
    logic [15:0]         r_fifo [2];
    logic                r_wp;
    logic                r_rp;
    logic [1:0]          r_occ;
    logic                r_inflight;

    logic                w_accept;
    logic                w_wr_beat;
    logic                w_pop;
    logic                w_credit;
    logic                w_issue;
    logic                w_flush_ok;
    logic [1:0]          w_mask;
    logic [2:0]          w_slots;

`ifdef DMEM_BURST_BE_EN
    logic [1:0]          r_be;
    assign w_mask = r_be;
`else
    assign w_mask = 2'b11;
`endif

    assign w_accept   = (r_state == S_IDLE) && r_live && cmd_valid;
    assign w_wr_beat  = (r_state == S_WRITE) && wdata_valid;
    assign w_pop      = (r_occ != 2'd0) && rdata_ready;
    // A word popped this cycle frees its slot before the new read's data lands.
    assign w_slots    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_credit   = (w_slots < 3'd2);
    assign w_issue    = (r_state == S_READ) && w_credit;
    assign w_flush_ok = r_wr || ((r_occ == 2'd0) && !r_inflight);

    assign rdata_valid = (r_occ != 2'd0);
    assign rdata       = r_fifo[r_rp];
    assign addra       = r_addr;
    assign busy        = (r_state != S_IDLE);

    always_comb begin
        w_next      = r_state;
        cmd_ready   = 1'b0;
        wdata_ready = 1'b0;
        ena         = 1'b0;
        wea         = 2'b00;
        dina        = 16'h0000;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = r_live;
                if (r_live && cmd_valid) begin
                    w_next = cmd_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                wdata_ready = 1'b1;
                if (wdata_valid) begin
                    ena  = 1'b1;
                    wea  = w_mask;
                    dina = wdata;
                    if (r_cnt == 8'd0) begin
                        w_next = S_FLUSH;
                    end
                end
            end
            S_READ: begin
                ena = w_issue;
                if (w_issue && (r_cnt == 8'd0)) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_flush_ok) begin
                    done   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_live  <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_cnt   <= 8'd0;
`ifdef DMEM_BURST_BE_EN
            r_be    <= 2'b00;
`endif
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_wr   <= cmd_write;
                r_addr <= cmd_addr;
                r_cnt  <= cmd_len;
`ifdef DMEM_BURST_BE_EN
                r_be   <= cmd_be;
`endif
            end else if (w_wr_beat || w_issue) begin
                r_addr <= r_addr + 1'b1;
                if (r_cnt != 8'd0) begin
                    r_cnt <= r_cnt - 8'd1;
                end
            end
        end
    end

    // RAM data is valid the cycle after a read enable, so capture follows r_inflight.
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_fifo[0]  <= 16'h0000;
            r_fifo[1]  <= 16'h0000;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo[r_wp] <= douta;
                r_wp         <= ~r_wp;
            end
            if (w_pop) begin
                r_rp <= ~r_rp;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule

// File: tb/tb_dmem_burst_master.sv
// Bench for dmem_burst_master: behavioural RAM, directed write/read bursts, wrap, mid-burst reset, byte mask.
module tb_dmem_burst_master;

    logic        mclk = 1'b0;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [9:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic [1:0]  cmd_be;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [15:0] wdata;
    logic        rdata_valid;
    logic        rdata_ready;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        ena;
    logic [1:0]  wea;
    logic [9:0]  addra;
    logic [15:0] dina;
    logic [15:0] douta;

    logic [15:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    always #5 mclk = ~mclk;

    dmem_burst_master #(.ADDR_MSB(9)) dut (
        .mclk        (mclk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_len     (cmd_len),
`ifdef DMEM_BURST_BE_EN
        .cmd_be      (cmd_be),
`endif
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata_ready (rdata_ready),
        .rdata       (rdata),
        .busy        (busy),
        .done        (done),
        .ena         (ena),
        .wea         (wea),
        .addra       (addra),
        .dina        (dina),
        .douta       (douta)
    );

    // Single-port RAM with byte writes and one-cycle read latency.
    always @(posedge mclk) begin
        if (ena) begin
            if (wea[0]) mem[addra][7:0]  <= dina[7:0];
            if (wea[1]) mem[addra][15:8] <= dina[15:8];
            if (wea == 2'b00) douta <= mem[addra];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".cmd_ready"},   cmd_ready,   0);
        chk({tag, ".busy"},        busy,        0);
        chk({tag, ".done"},        done,        0);
        chk({tag, ".ena"},         ena,         0);
        chk({tag, ".wea"},         wea,         0);
        chk({tag, ".addra"},       addra,       0);
        chk({tag, ".dina"},        dina,        0);
        chk({tag, ".wdata_ready"}, wdata_ready, 0);
        chk({tag, ".rdata_valid"}, rdata_valid, 0);
        chk({tag, ".rdata"},       rdata,       0);
    endtask

    task automatic write_burst(input logic [9:0] addr, input int len, input logic [15:0] base,
                               input logic [15:0] step, input logic [1:0] be);
        logic [9:0]  ea;
        logic [1:0]  ew;
`ifdef DMEM_BURST_BE_EN
        ew = be;
`else
        ew = 2'b11;
`endif
        @(negedge mclk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = 8'(len); cmd_be = be;
        #1 chk("wr.cmd_ready", cmd_ready, 1);
        for (int i = 0; i <= len; i++) begin
            @(negedge mclk);
            cmd_valid   = 1'b0;
            wdata_valid = 1'b1;
            wdata       = base + 16'(i) * step;
            ea          = addr + 10'(i);
            #1;
            chk($sformatf("wr.ena[%0d]", i),   ena,   1);
            chk($sformatf("wr.wea[%0d]", i),   wea,   ew);
            chk($sformatf("wr.addra[%0d]", i), addra, ea);
            chk($sformatf("wr.dina[%0d]", i),  dina,  wdata);
        end
        @(negedge mclk);
        wdata_valid = 1'b0;
        #1;
        chk("wr.done", done, 1);
        chk("wr.ena_after", ena, 0);
        @(negedge mclk);
        #1;
        chk("wr.busy_after", busy, 0);
        chk("wr.done_after", done, 0);
    endtask

    // mode 0: rdata_ready held high; mode 1: rdata_ready toggles 1,0,1,0...
    task automatic read_burst(input logic [9:0] addr, input int len, input int mode,
                              input logic [15:0] base, input logic [15:0] step, input bit timing);
        int occ = 0;
        int infl = 0;
        int got = 0;
        int issued = 0;
        int done_cnt = 0;
        int first_k = -1;
        int last_k = -1;
        bit fin = 0;
        int pop;
        @(negedge mclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = 8'(len); rdata_ready = 1'b1;
        #1 chk("rd.cmd_ready", cmd_ready, 1);
        for (int k = 0; k < 200 && !fin; k++) begin
            @(negedge mclk);
            cmd_valid   = 1'b0;
            rdata_ready = (mode == 0) ? 1'b1 : (k % 2 == 0);
            #1;
            pop = (rdata_valid && rdata_ready) ? 1 : 0;
            if (rdata_valid !== (occ != 0)) chk($sformatf("rd.valid[k%0d]", k), rdata_valid, occ != 0);
            if (ena) begin
                chk($sformatf("rd.wea[%0d]", issued), wea, 0);
                chk($sformatf("rd.credit[%0d]", issued), (occ + infl - pop) < 2, 1);
                chk($sformatf("rd.addra[%0d]", issued), addra, 10'(addr + 10'(issued)));
                issued++;
            end
            if (pop != 0) begin
                chk($sformatf("rd.data[%0d]", got), rdata, base + 16'(got) * step);
                if (got == 0) first_k = k;
                last_k = k;
                got++;
            end
            if (done) begin
                done_cnt++;
                chk("rd.done_after_last", got, len + 1);
                fin = 1;
            end
            occ  = occ + infl - pop;
            infl = (ena && wea == 2'b00) ? 1 : 0;
        end
        chk("rd.done_seen", done_cnt, 1);
        chk("rd.issued", issued, len + 1);
        if (timing) begin
            chk("rd.first_valid_k", first_k, 2);
            chk("rd.back_to_back", last_k, len + 2);
        end
        @(negedge mclk);
        #1 chk("rd.busy_after", busy, 0);
    endtask

    typedef struct {
        logic        cv;
        logic        wv;
        logic [15:0] wd;
        logic        e_crdy;
        logic        e_wrdy;
        logic        e_ena;
        logic [1:0]  e_wea;
        logic [9:0]  e_addr;
        logic [15:0] e_dina;
        logic        e_busy;
        logic        e_done;
    } wvec_t;

    wvec_t wt [8];

    initial begin
        int got;
        int late_done;
        logic [15:0] exp_be;

        // cmd, wv, wd, crdy, wrdy, ena, wea, addra, dina, busy, done
        wt[0] = '{1'b1, 1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b0, 2'b00, 10'h000, 16'h0000, 1'b0, 1'b0};
        wt[1] = '{1'b0, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 2'b11, 10'h010, 16'h1111, 1'b1, 1'b0};
        wt[2] = '{1'b0, 1'b0, 16'h9999, 1'b0, 1'b1, 1'b0, 2'b00, 10'h011, 16'h0000, 1'b1, 1'b0};
        wt[3] = '{1'b0, 1'b1, 16'h2222, 1'b0, 1'b1, 1'b1, 2'b11, 10'h011, 16'h2222, 1'b1, 1'b0};
        wt[4] = '{1'b0, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b1, 2'b11, 10'h012, 16'h3333, 1'b1, 1'b0};
        wt[5] = '{1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b1, 2'b11, 10'h013, 16'h4444, 1'b1, 1'b0};
        wt[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 10'h014, 16'h0000, 1'b1, 1'b1};
        wt[7] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 10'h014, 16'h0000, 1'b0, 1'b0};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        cmd_be = 2'b11; wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;

        repeat (3) @(negedge mclk);
        #1 chk_reset_outputs("rst");
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (2) @(negedge mclk);
        #1;
        chk("rst.cmd_ready_after", cmd_ready, 1);
        chk("rst.busy_after", busy, 0);

        cmd_write = 1'b1; cmd_addr = 10'h010; cmd_len = 8'd3; cmd_be = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge mclk);
            cmd_valid = wt[i].cv; wdata_valid = wt[i].wv; wdata = wt[i].wd;
            #1;
            chk($sformatf("wt%0d.cmd_ready", i),   cmd_ready,   wt[i].e_crdy);
            chk($sformatf("wt%0d.wdata_ready", i), wdata_ready, wt[i].e_wrdy);
            chk($sformatf("wt%0d.ena", i),         ena,         wt[i].e_ena);
            chk($sformatf("wt%0d.wea", i),         wea,         wt[i].e_wea);
            chk($sformatf("wt%0d.addra", i),       addra,       wt[i].e_addr);
            chk($sformatf("wt%0d.dina", i),        dina,        wt[i].e_dina);
            chk($sformatf("wt%0d.busy", i),        busy,        wt[i].e_busy);
            chk($sformatf("wt%0d.done", i),        done,        wt[i].e_done);
        end

        read_burst(10'h010, 3, 0, 16'h1111, 16'h1111, 1'b1);

        write_burst(10'h020, 7, 16'h0101, 16'h0101, 2'b11);
        read_burst(10'h020, 7, 1, 16'h0101, 16'h0101, 1'b0);

        write_burst(10'h3FE, 3, 16'hA000, 16'h0001, 2'b11);
        read_burst(10'h3FE, 3, 0, 16'hA000, 16'h0001, 1'b1);

        // Abort a read burst with reset after the third word leaves the buffer.
        @(negedge mclk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 10'h020; cmd_len = 8'd7; rdata_ready = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && got < 3; k++) begin
            @(negedge mclk);
            cmd_valid = 1'b0;
            #1;
            if (rdata_valid && rdata_ready) begin
                chk($sformatf("abort.data[%0d]", got), rdata, 16'h0101 * 16'(got + 1));
                got++;
            end
        end
        chk("abort.words_before_reset", got, 3);
        #1 reset_n = 1'b0;
        #1 chk_reset_outputs("abort");
        repeat (2) @(negedge mclk);
        reset_n = 1'b1;
        late_done = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge mclk);
            #1;
            if (done || busy || rdata_valid) late_done++;
        end
        chk("abort.no_done_or_data", late_done, 0);
        read_burst(10'h010, 0, 0, 16'h1111, 16'h0000, 1'b1);

        write_burst(10'h000, 0, 16'h0000, 16'h0000, 2'b11);
        write_burst(10'h000, 0, 16'hABCD, 16'h0000, 2'b01);
`ifdef DMEM_BURST_BE_EN
        exp_be = 16'h00CD;
`else
        exp_be = 16'hABCD;
`endif
        read_burst(10'h000, 0, 0, exp_be, 16'h0000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1);
    end

endmodule
